bnn_infer_sequencer: RTL and testbench
======================================

// Module: bnn_infer_sequencer
// PURPOSE
//  Sequences one BNN classifier core (features/clk/rst/prediction) over a stream of samples.
//  Accepts feature vectors on a valid/ready input and buffers one pending sample.
//  Holds features stable, pulses core reset, waits the core's fixed compute latency,
//  then returns the captured class on a valid/ready output.
//  Sits between the sample source (ROM/stream) and the result consumer.
// PARAMETERS
//  FEAT_CNT    128    features per sample
//  FEAT_BITS   4      bits per feature
//  HIDDEN_CNT  40     hidden neurons in core (sets latency)
//  CLASS_CNT   6      output classes
//  WAIT_CYC    HIDDEN_CNT+CLASS_CNT+1   cycles in RUN after core reset deasserts
//  CNT_W       16     width of completed-inference counter
// PORTS
//  clk            in   1                       single clock, rising edge
//  rst            in   1                       synchronous reset, active-high
//  in_valid       in   1                       sample offered
//  in_ready       out  1                       = !pend_valid
//  in_features    in   FEAT_BITS*FEAT_CNT      sample vector
//  core_features  out  FEAT_BITS*FEAT_CNT      to core .features; = feat_q
//  core_rst       out  1                       to core .rst; = rst | (state==LOAD)
//  core_pred      in   $clog2(CLASS_CNT)       from core .prediction
//  pred_valid     out  1                       result available
//  pred_ready     in   1                       consumer accepts result
//  pred_data      out  $clog2(CLASS_CNT)       captured class
//  busy           out  1                       state != IDLE
//  done_cnt       out  CNT_W                   results handed off; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state=IDLE, pend_valid=0, feat_q=0, pend_q=0, pred_valid=0, pred_data=0,
//   cnt=0, done_cnt=0. in_ready therefore 1 the cycle after reset; core_rst=1 during reset.
//  Input fire = in_valid & in_ready: pend_q<=in_features, pend_valid<=1. in_ready low while full.
//  FSM:
//   IDLE: if pend_valid: feat_q<=pend_q, pend_valid<=0 -> LOAD.
//   LOAD: 1 cycle, core_rst=1, cnt<=0 -> RUN.
//   RUN: cnt++ each cycle; when cnt==WAIT_CYC-1: pred_data<=core_pred, pred_valid<=1 -> DONE.
//   DONE: hold pred_valid/pred_data until pred_ready. On handoff: pred_valid<=0, done_cnt++;
//    if pend_valid: feat_q<=pend_q, pend_valid<=0 -> LOAD (back-to-back); else -> IDLE.
//  Pending dequeue and input fire never coincide (in_ready=!pend_valid); a fire while
//   pend_valid is 0 in the same cycle a dequeue would occur is impossible.
//  feat_q only changes on IDLE->LOAD or DONE->LOAD; stable through LOAD, RUN, DONE.
//  Latency: fire at cycle t (IDLE, empty) -> LOAD at t+2 -> pred_valid first high at
//   t+3+WAIT_CYC (t+50 with defaults). pred_ready may be high on arrival: handoff same cycle.
//  pred_ready while pred_valid=0 is ignored; in_valid while in_ready=0 is ignored (no drop
//   of held data, source must hold).
//  rst mid-operation (any state): abort, pending and in-flight results discarded, all regs to
//   reset values next cycle; done_cnt cleared.
//  cnt width $clog2(WAIT_CYC+1); no other arithmetic; done_cnt wraps silently.
// TESTING
//  1 single sample A, pred_ready=1, core model returns 3 -> pred_valid at t+50, pred_data=3,
//    done_cnt=1, busy drops next cycle.
//  2 samples A,B offered back-to-back -> B held in pend (in_ready=0 until A dequeued), B's
//    LOAD follows A's handoff directly, results in order, done_cnt=2.
//  3 pred_ready=0 for 20 cycles after pred_valid -> pred_valid/pred_data stable, feat_q stable,
//    core_rst=0, C arriving is buffered but not loaded until handoff.
//  4 rst asserted mid-RUN (cnt=10) with sample pending -> next cycle IDLE, pend_valid=0,
//    pred_valid=0, done_cnt=0, core_rst=1 while rst high.
//  5 core_features check: core_rst high exactly 1 cycle per sample; core_features equal to the
//    sample throughout LOAD..DONE; 1000-vector ROM run matches golden predictions.
//  6 done_cnt wrap with CNT_W=2: 5 samples -> done_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/bnn_infer_sequencer_if.sv
// Sample-in / prediction-out stream bundle for the BNN inference sequencer.
// master: sample source plus result consumer. slave: the sequencer.
interface bnn_infer_sequencer_if #(
    parameter int unsigned FEAT_W = 512,
    parameter int unsigned PRED_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [FEAT_W-1:0] in_features;
    logic              pred_valid;
    logic              pred_ready;
    logic [PRED_W-1:0] pred_data;

    modport master (
        output in_valid, in_features, pred_ready,
        input  in_ready, pred_valid, pred_data
    );

    modport slave (
        input  in_valid, in_features, pred_ready,
        output in_ready, pred_valid, pred_data
    );
endinterface

// File: rtl/bnn_infer_sequencer.sv
// Drives one BNN classifier core over a stream of samples: buffers one pending
// sample, holds features stable, pulses core reset, waits the core's fixed
// latency and hands the captured class to the consumer.
module bnn_infer_sequencer #(
    parameter int unsigned FEAT_CNT   = 128,
    parameter int unsigned FEAT_BITS  = 4,
    parameter int unsigned HIDDEN_CNT = 40,
    parameter int unsigned CLASS_CNT  = 6,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned FEAT_W    = FEAT_BITS * FEAT_CNT,
    localparam int unsigned PRED_W    = $clog2(CLASS_CNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    bnn_infer_sequencer_if.slave  io,
    output logic [FEAT_W-1:0]     core_features,
    output logic                  core_rst,
    input  logic [PRED_W-1:0]     core_pred,
    output logic                  busy,
    output logic [CNT_W-1:0]      done_cnt
);
    // Cycles spent in StRun after the core leaves reset before its output is valid.
    localparam int unsigned WAIT_CYC = HIDDEN_CNT + CLASS_CNT + 1;
    localparam int unsigned CYC_W    = $clog2(WAIT_CYC + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WAIT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e            state_q;
    logic              pend_valid_q;
    logic [FEAT_W-1:0] pend_q;
    logic [FEAT_W-1:0] feat_q;
    logic              pred_valid_q;
    logic [PRED_W-1:0] pred_data_q;
    logic [CYC_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  done_cnt_q;

    // Sequencer FSM with the one-deep pending buffer and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            feat_q       <= '0;
            pred_valid_q <= 1'b0;
            pred_data_q  <= '0;
            cnt_q        <= '0;
            done_cnt_q   <= '0;
        end else begin
            // Accept only into an empty buffer, so this never races a dequeue below.
            if (io.in_valid && !pend_valid_q) begin
                pend_q       <= io.in_features;
                pend_valid_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (pend_valid_q) begin
                        feat_q       <= pend_q;
                        pend_valid_q <= 1'b0;
                        state_q      <= StLoad;
                    end
                end
                StLoad: begin
                    cnt_q   <= '0;
                    state_q <= StRun;
                end
                StRun: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CYC_LAST) begin
                        pred_data_q  <= core_pred;
                        pred_valid_q <= 1'b1;
                        state_q      <= StDone;
                    end
                end
                StDone: begin
                    if (io.pred_ready) begin
                        pred_valid_q <= 1'b0;
                        done_cnt_q   <= done_cnt_q + 1'b1;
                        if (pend_valid_q) begin
                            feat_q       <= pend_q;
                            pend_valid_q <= 1'b0;
                            state_q      <= StLoad;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign io.in_ready   = !pend_valid_q;
    assign io.pred_valid = pred_valid_q;
    assign io.pred_data  = pred_data_q;
    assign core_features = feat_q;
    assign core_rst      = rst | (state_q == StLoad);
    assign busy          = (state_q != StIdle);
    assign done_cnt      = done_cnt_q;
endmodule

// File: tb/tb_bnn_infer_sequencer.sv
// Bench for bnn_infer_sequencer: a latency-accurate core stand-in plus a
// scoreboard of per-sample class predictions computed from the features.
module tb_bnn_infer_sequencer;
    localparam int FEAT_CNT   = 128;
    localparam int FEAT_BITS  = 4;
    localparam int HIDDEN_CNT = 40;
    localparam int CLASS_CNT  = 6;
    localparam int CNT_W      = 2;
    localparam int WAIT_CYC   = HIDDEN_CNT + CLASS_CNT + 1;
    localparam int FW         = FEAT_BITS * FEAT_CNT;
    localparam int PW         = $clog2(CLASS_CNT);
    localparam int LAT        = 3 + WAIT_CYC;
    localparam int ROM_N      = 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic [FW-1:0]     core_features;
    logic              core_rst;
    logic [PW-1:0]     core_pred;
    logic              busy;
    logic [CNT_W-1:0]  done_cnt;
    int                core_c;
    int                checks = 0;
    int                errors = 0;
    int                exp_done = 0;
    logic [FW-1:0]     rom [ROM_N];

    bnn_infer_sequencer_if #(.FEAT_W(FW), .PRED_W(PW)) bus ();

    bnn_infer_sequencer #(
        .FEAT_CNT(FEAT_CNT), .FEAT_BITS(FEAT_BITS), .HIDDEN_CNT(HIDDEN_CNT),
        .CLASS_CNT(CLASS_CNT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .io(bus.slave), .core_features(core_features),
        .core_rst(core_rst), .core_pred(core_pred), .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    // Reference classifier: sum of feature values modulo the class count.
    function automatic logic [PW-1:0] golden(input logic [FW-1:0] f);
        int s;
        s = 0;
        for (int i = 0; i < FEAT_CNT; i++) s += int'(f[i*FEAT_BITS +: FEAT_BITS]);
        return PW'(s % CLASS_CNT);
    endfunction

    function automatic logic [FW-1:0] rand_feat();
        logic [FW-1:0] f;
        for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom();
        return f;
    endfunction

    // Core stand-in: output is only correct from the WAIT_CYC-th cycle after reset release.
    always @(posedge clk) core_c <= core_rst ? 0 : ((core_c < 1000) ? core_c + 1 : core_c);
    assign core_pred = (core_c >= WAIT_CYC - 1) ? golden(core_features)
                                                : PW'((int'(golden(core_features)) + 1) % CLASS_CNT);

    // Waits for pred_valid; reports cycle index, core reset pulses and feature instability.
    task automatic wait_valid(input logic [FW-1:0] exp_f, input bit from_start, output int k,
                              output int rst_cnt, output int rst_at, output int feat_bad);
        bit chk;
        k = -1; rst_cnt = 0; rst_at = -1; feat_bad = 0; chk = from_start;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (core_rst) begin
                rst_cnt++;
                if (rst_at < 0) rst_at = i;
                chk = 1'b1;
            end
            if (chk && core_features !== exp_f) feat_bad++;
            if (bus.pred_valid) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.in_valid = 1'b0; bus.pred_ready = 1'b0; bus.in_features = '0;
        repeat (2) @(negedge clk);
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst got %b want 1", core_rst); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.pred_valid !== 1'b0 || bus.pred_data !== '0) begin
            errors++; $display("FAIL reset_pred got v=%b d=%0d want v=0 d=0", bus.pred_valid, bus.pred_data); end
        checks++; if (busy !== 1'b0 || done_cnt !== '0 || core_rst !== 1'b0) begin
            errors++; $display("FAIL reset_state got busy=%b done=%0d crst=%b want 0 0 0", busy, done_cnt, core_rst); end
        checks++; if (core_features !== '0) begin errors++; $display("FAIL reset_features got nonzero want 0"); end
    endtask

    task automatic test_single();
        logic [FW-1:0] a;
        int k, rc, ra, fb;
        a = rand_feat();
        for (int i = 0; i < 2000 && golden(a) != 3'd3; i++) a = rand_feat();
        bus.pred_ready = 1'b1; bus.in_valid = 1'b1; bus.in_features = a;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL single_in_ready_full got %b want 0", bus.in_ready); end
        wait_valid(a, 1'b0, k, rc, ra, fb);
        checks++; if (k != LAT - 1) begin errors++; $display("FAIL single_latency got %0d want %0d", k + 1, LAT); end
        checks++; if (rc != 1 || ra != 1) begin errors++; $display("FAIL single_core_rst got cnt=%0d at=%0d want 1 1", rc, ra); end
        checks++; if (fb != 0) begin errors++; $display("FAIL single_features got %0d bad cycles want 0", fb); end
        checks++; if (bus.pred_data !== 3'd3) begin errors++; $display("FAIL single_pred got %0d want 3", bus.pred_data); end
        exp_done++;
        @(negedge clk);
        checks++; if (done_cnt !== CNT_W'(exp_done % 4) || busy !== 1'b0 || bus.pred_valid !== 1'b0) begin
            errors++; $display("FAIL single_handoff got done=%0d busy=%b v=%b want %0d 0 0", done_cnt, busy,
                               bus.pred_valid, exp_done % 4); end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] a, b;
        int k, rc, ra, fb;
        a = rand_feat(); b = rand_feat();
        bus.pred_ready = 1'b1; bus.in_valid = 1'b1; bus.in_features = a;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold_b got in_ready=%b want 0", bus.in_ready); end
        bus.in_features = b;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept_b got in_ready=%b want 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_pend_full got in_ready=%b want 0", bus.in_ready); end
        wait_valid(a, 1'b1, k, rc, ra, fb);
        checks++; if (k != LAT - 3 || rc != 0 || fb != 0) begin
            errors++; $display("FAIL b2b_first got k=%0d rst=%0d fbad=%0d want %0d 0 0", k, rc, fb, LAT - 3); end
        checks++; if (bus.pred_data !== golden(a)) begin errors++; $display("FAIL b2b_pred_a got %0d want %0d", bus.pred_data, golden(a)); end
        exp_done++;
        wait_valid(b, 1'b0, k, rc, ra, fb);
        checks++; if (k != WAIT_CYC + 2 || rc != 1 || ra != 1 || fb != 0) begin
            errors++; $display("FAIL b2b_second got k=%0d rst=%0d at=%0d fbad=%0d want %0d 1 1 0", k, rc, ra, fb, WAIT_CYC + 2); end
        checks++; if (bus.pred_data !== golden(b)) begin errors++; $display("FAIL b2b_pred_b got %0d want %0d", bus.pred_data, golden(b)); end
        exp_done++;
        @(negedge clk);
        checks++; if (done_cnt !== CNT_W'(exp_done % 4) || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_done got done=%0d busy=%b want %0d 0", done_cnt, busy, exp_done % 4); end
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] a, c;
        int k, rc, ra, fb, bad;
        a = rand_feat(); c = rand_feat(); bad = 0;
        bus.pred_ready = 1'b0; bus.in_valid = 1'b1; bus.in_features = a;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(a, 1'b0, k, rc, ra, fb);
        checks++; if (k != LAT - 1) begin errors++; $display("FAIL bp_latency got %0d want %0d", k + 1, LAT); end
        for (int j = 0; j < 20; j++) begin
            if (bus.pred_valid !== 1'b1 || bus.pred_data !== golden(a) || core_features !== a ||
                core_rst !== 1'b0) bad++;
            if (j == 2) begin
                bus.in_valid = 1'b1; bus.in_features = c;
                if (bus.in_ready !== 1'b1) bad++;
            end
            if (j == 3) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
        checks++; if (bus.in_ready !== 1'b0 || core_features !== a) begin
            errors++; $display("FAIL bp_buffered got in_ready=%b feat_is_a=%b want 0 1", bus.in_ready, core_features === a); end
        bus.pred_ready = 1'b1;
        exp_done++;
        wait_valid(c, 1'b0, k, rc, ra, fb);
        checks++; if (k != WAIT_CYC + 2 || rc != 1 || ra != 1 || fb != 0) begin
            errors++; $display("FAIL bp_c_load got k=%0d rst=%0d at=%0d fbad=%0d want %0d 1 1 0", k, rc, ra, fb, WAIT_CYC + 2); end
        checks++; if (bus.pred_data !== golden(c)) begin errors++; $display("FAIL bp_pred_c got %0d want %0d", bus.pred_data, golden(c)); end
        exp_done++;
        @(negedge clk);
        checks++; if (done_cnt !== CNT_W'(exp_done % 4) || busy !== 1'b0) begin
            errors++; $display("FAIL bp_done got done=%0d busy=%b want %0d 0", done_cnt, busy, exp_done % 4); end
    endtask

    task automatic test_rst_mid();
        int seen;
        bus.pred_ready = 1'b1; bus.in_valid = 1'b1; bus.in_features = rand_feat();
        @(negedge clk);
        bus.in_features = rand_feat();
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid_pre got busy=%b in_ready=%b want 1 0", busy, bus.in_ready); end
        rst = 1'b1;
        #1;
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL rst_mid_core_rst got %b want 1", core_rst); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.pred_valid !== 1'b0 || done_cnt !== '0 ||
                      core_rst !== 1'b1 || core_features !== '0) begin
            errors++; $display("FAIL rst_mid_cleared got busy=%b in_ready=%b v=%b done=%0d crst=%b want 0 1 0 0 1",
                               busy, bus.in_ready, bus.pred_valid, done_cnt, core_rst); end
        rst = 1'b0;
        exp_done = 0;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.pred_valid || busy) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_discard got %0d active cycles want 0", seen); end
    endtask

    task automatic test_wrap();
        int seq [5];
        logic [FW-1:0] s;
        int k, rc, ra, fb;
        seq = '{1, 2, 3, 0, 1};
        bus.pred_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s = rand_feat();
            bus.in_valid = 1'b1; bus.in_features = s;
            @(negedge clk);
            bus.in_valid = 1'b0;
            wait_valid(s, 1'b0, k, rc, ra, fb);
            checks++; if (k < 0 || bus.pred_data !== golden(s)) begin
                errors++; $display("FAIL wrap_pred%0d got %0d want %0d (k=%0d)", i, bus.pred_data, golden(s), k); end
            exp_done++;
            @(negedge clk);
            checks++; if (int'(done_cnt) != seq[i]) begin
                errors++; $display("FAIL wrap_cnt%0d got %0d want %0d", i, done_cnt, seq[i]); end
        end
    endtask

    task automatic test_rom_run();
        int sent, recv, loads, bad_pred, bad_done, bad_load, cyc;
        bit fire;
        for (int i = 0; i < ROM_N; i++) rom[i] = rand_feat();
        sent = 0; recv = 0; loads = 0; bad_pred = 0; bad_done = 0; bad_load = 0; cyc = 0;
        bus.in_valid = 1'b1; bus.in_features = rom[0];
        while (recv < ROM_N && cyc < 70000) begin
            bus.pred_ready = ($urandom_range(0, 3) != 0);
            if (done_cnt !== CNT_W'(exp_done % 4)) bad_done++;
            if (core_rst) begin
                if (loads >= ROM_N || core_features !== rom[loads]) bad_load++;
                loads++;
            end
            if (bus.pred_valid && bus.pred_ready) begin
                if (bus.pred_data !== golden(rom[recv])) bad_pred++;
                recv++;
                exp_done++;
            end
            fire = bus.in_valid && bus.in_ready;
            @(negedge clk);
            cyc++;
            if (fire) begin
                sent++;
                if (sent < ROM_N) bus.in_features = rom[sent];
                else bus.in_valid = 1'b0;
            end
        end
        checks++; if (recv != ROM_N || sent != ROM_N) begin
            errors++; $display("FAIL rom_count got sent=%0d recv=%0d want %0d", sent, recv, ROM_N); end
        checks++; if (bad_pred != 0) begin errors++; $display("FAIL rom_pred got %0d wrong want 0", bad_pred); end
        checks++; if (bad_done != 0) begin errors++; $display("FAIL rom_done_cnt got %0d wrong cycles want 0", bad_done); end
        checks++; if (loads != ROM_N || bad_load != 0) begin
            errors++; $display("FAIL rom_load got loads=%0d bad=%0d want %0d 0", loads, bad_load, ROM_N); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_rst_mid();
        test_wrap();
        test_rom_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
